// File: rtl/safe_lock_supervisor.sv
// Supervisor behind the safe-code comparator: syncs open_n/fail_n, counts failures,
// times the open window and a blinking lockout. Define SAFE_LOCK_BUZZER_EN to add a lockout buzzer.
module safe_lock_supervisor #(
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned OPEN_CYCLES    = 50000000,
  parameter int unsigned LOCKOUT_CYCLES = 500000000,
  parameter int unsigned BLINK_HALF     = 12500000
`ifdef SAFE_LOCK_BUZZER_EN
  ,
  parameter int unsigned BUZZ_HALF      = 25000
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            open_n,
  input  logic                            fail_n,
  output logic                            safe_open_n,
  output logic                            alarm_led_n,
  output logic                            lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
`ifdef SAFE_LOCK_BUZZER_EN
  ,
  output logic                            buzzer
`endif
);

  localparam int unsigned FCW  = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [FCW-1:0] FC_MAX     = FCW'(MAX_FAIL);
  localparam logic [FCW-1:0] FC_LAST    = FCW'(MAX_FAIL - 1);
  localparam logic [TW-1:0]  OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0]  LOCK_LOAD  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  logic [1:0]     open_sync_q, fail_sync_q;
  logic           open_s, fail_s;
  logic           cls_idle, cls_success, cls_failure;
  logic           evt_success, evt_failure;

  logic [1:0]     state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
  logic           blink_on_q, blink_on_d;
  logic           armed_q, armed_d;
  logic [FCW-1:0] fail_cnt_d;
  logic           safe_open_n_d, alarm_led_n_d, lockout_d;

`ifdef SAFE_LOCK_BUZZER_EN
  localparam int unsigned ZW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
  localparam logic [ZW-1:0] BUZZ_LAST = ZW'(BUZZ_HALF - 1);
  logic [ZW-1:0]  buzz_cnt_q, buzz_cnt_d;
  logic           buzzer_d;
`else
  // Buzzer absent: no counter or output in this build.
`endif

  // Two-flop synchronizers for the asynchronous comparator outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_sync_q <= 2'b11;
      fail_sync_q <= 2'b11;
    end else begin
      open_sync_q <= {open_sync_q[0], open_n};
      fail_sync_q <= {fail_sync_q[0], fail_n};
    end
  end

  assign open_s      = open_sync_q[1];
  assign fail_s      = fail_sync_q[1];
  assign cls_idle    = open_s & fail_s;
  assign cls_success = ~open_s & fail_s;
  assign cls_failure = open_s & ~fail_s;
  assign evt_success = armed_q & cls_success;
  assign evt_failure = armed_q & cls_failure;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      armed_q     <= 1'b1;
      fail_cnt    <= '0;
      safe_open_n <= 1'b1;
      alarm_led_n <= 1'b1;
      lockout     <= 1'b0;
`ifdef SAFE_LOCK_BUZZER_EN
      buzz_cnt_q  <= '0;
      buzzer      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      armed_q     <= armed_d;
      fail_cnt    <= fail_cnt_d;
      safe_open_n <= safe_open_n_d;
      alarm_led_n <= alarm_led_n_d;
      lockout     <= lockout_d;
`ifdef SAFE_LOCK_BUZZER_EN
      buzz_cnt_q  <= buzz_cnt_d;
      buzzer      <= buzzer_d;
`endif
    end
  end

  // Next state and next output values
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    blink_cnt_d   = blink_cnt_q;
    blink_on_d    = blink_on_q;
    armed_d       = armed_q;
    fail_cnt_d    = fail_cnt;
    safe_open_n_d = 1'b1;
    alarm_led_n_d = 1'b1;
    lockout_d     = 1'b0;
`ifdef SAFE_LOCK_BUZZER_EN
    buzz_cnt_d    = buzz_cnt_q;
    buzzer_d      = 1'b0;
`endif

    // One event per key press; invalid (both low) neither fires nor re-arms
    if (evt_success || evt_failure) begin
      armed_d = 1'b0;
    end else if (cls_idle) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        alarm_led_n_d = fail_s;
        if (evt_success) begin
          state_d       = ST_OPEN;
          fail_cnt_d    = '0;
          timer_d       = OPEN_LOAD;
          safe_open_n_d = 1'b0;
          alarm_led_n_d = 1'b1;
        end else if (evt_failure) begin
          if (fail_cnt < FC_LAST) begin
            fail_cnt_d = fail_cnt + FCW'(1);
          end else begin
            state_d       = ST_LOCKOUT;
            fail_cnt_d    = FC_MAX;
            timer_d       = LOCK_LOAD;
            blink_cnt_d   = '0;
            blink_on_d    = 1'b1;
            lockout_d     = 1'b1;
            alarm_led_n_d = 1'b0;
`ifdef SAFE_LOCK_BUZZER_EN
            buzz_cnt_d    = '0;
            buzzer_d      = 1'b1;
`endif
          end
        end
      end

      ST_OPEN: begin
        if (timer_q == '0) begin
          state_d       = ST_IDLE;
          alarm_led_n_d = fail_s;
        end else begin
          timer_d       = timer_q - TW'(1);
          safe_open_n_d = 1'b0;
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d     = ST_IDLE;
          fail_cnt_d  = '0;
          blink_cnt_d = '0;
          blink_on_d  = 1'b0;
`ifdef SAFE_LOCK_BUZZER_EN
          buzz_cnt_d  = '0;
`endif
        end else begin
          timer_d   = timer_q - TW'(1);
          lockout_d = 1'b1;
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
          alarm_led_n_d = ~blink_on_d;
`ifdef SAFE_LOCK_BUZZER_EN
          if (buzz_cnt_q == BUZZ_LAST) begin
            buzz_cnt_d = '0;
            buzzer_d   = ~buzzer;
          end else begin
            buzz_cnt_d = buzz_cnt_q + ZW'(1);
            buzzer_d   = buzzer;
          end
`endif
        end
      end

      default: begin
        state_d     = ST_IDLE;
        timer_d     = '0;
        blink_cnt_d = '0;
        blink_on_d  = 1'b0;
        fail_cnt_d  = '0;
`ifdef SAFE_LOCK_BUZZER_EN
        buzz_cnt_d  = '0;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_safe_lock_supervisor.sv
// Directed bench for safe_lock_supervisor (MAX_FAIL=3, OPEN=8, LOCKOUT=20, BLINK_HALF=2).
module tb_safe_lock_supervisor;

  logic       clk;
  logic       rst_n;
  logic       open_n;
  logic       fail_n;
  logic       safe_open_n;
  logic       alarm_led_n;
  logic       lockout;
  logic [1:0] fail_cnt;
`ifdef SAFE_LOCK_BUZZER_EN
  logic       buzzer;
`endif

  int checks;
  int errors;
  int open_cnt;
  int fc_bad;
  int lock_cnt;
  int unsafe;

  safe_lock_supervisor #(
    .MAX_FAIL(3),
    .OPEN_CYCLES(8),
    .LOCKOUT_CYCLES(20),
    .BLINK_HALF(2)
`ifdef SAFE_LOCK_BUZZER_EN
    ,
    .BUZZ_HALF(3)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .open_n(open_n),
    .fail_n(fail_n),
    .safe_open_n(safe_open_n),
    .alarm_led_n(alarm_led_n),
    .lockout(lockout),
    .fail_cnt(fail_cnt)
`ifdef SAFE_LOCK_BUZZER_EN
    ,
    .buzzer(buzzer)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance n cycles, tallying open-LED cycles and any nonzero fail_cnt
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (safe_open_n === 1'b0) open_cnt++;
      if (fail_cnt !== 2'd0) fc_bad++;
    end
  endtask

  task automatic fail_pulse();
    fail_n = 1'b0;
    tick(3);
    fail_n = 1'b1;
    tick(3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    open_n = 1'b0;
    fail_n = 1'b1;

    // Reset with key held
    tick(3);
    chk("rst_safe", 32'(safe_open_n), 32'd1);
    chk("rst_alarm", 32'(alarm_led_n), 32'd1);
    chk("rst_lockout", 32'(lockout), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
`ifdef SAFE_LOCK_BUZZER_EN
    chk("rst_buzzer", 32'(buzzer), 32'd0);
`endif
    rst_n = 1'b1;
    tick(2);
    chk("rst_lat2", 32'(safe_open_n), 32'd1);
    tick(1);
    chk("rst_lat3", 32'(safe_open_n), 32'd0);
    open_n   = 1'b1;
    open_cnt = 0;
    run(15);
    chk("rst_open_rest", 32'(open_cnt), 32'd7);

    // Correct code, 5-cycle press
    open_cnt = 0;
    fc_bad   = 0;
    open_n   = 1'b0;
    run(5);
    open_n = 1'b1;
    run(20);
    chk("open_len", 32'(open_cnt), 32'd8);
    chk("open_fail_cnt", 32'(fc_bad), 32'd0);
    chk("open_closed", 32'(safe_open_n), 32'd1);

    // Held key gives one window only
    open_cnt = 0;
    open_n   = 1'b0;
    run(30);
    open_n = 1'b1;
    run(5);
    chk("held_one_window", 32'(open_cnt), 32'd8);
    open_cnt = 0;
    open_n   = 1'b0;
    run(3);
    open_n = 1'b1;
    run(15);
    chk("held_repulse", 32'(open_cnt), 32'd8);

    // Failure counting and alarm tracking
    fail_n = 1'b0;
    tick(2);
    chk("alm_d2", 32'(alarm_led_n), 32'd1);
    tick(1);
    chk("alm_d3", 32'(alarm_led_n), 32'd0);
    chk("fcnt1", 32'(fail_cnt), 32'd1);
    tick(1);
    fail_n = 1'b1;
    tick(2);
    chk("alm_rel_d2", 32'(alarm_led_n), 32'd0);
    tick(1);
    chk("alm_rel_d3", 32'(alarm_led_n), 32'd1);
    fail_n = 1'b0;
    tick(3);
    chk("fcnt2", 32'(fail_cnt), 32'd2);
    chk("fcnt2_lock", 32'(lockout), 32'd0);
    fail_n = 1'b1;
    tick(5);
    open_n = 1'b0;
    tick(3);
    chk("fc_open_safe", 32'(safe_open_n), 32'd0);
    chk("fc_open_clr", 32'(fail_cnt), 32'd0);
    open_n = 1'b1;
    tick(12);
    chk("fc_open_end", 32'(safe_open_n), 32'd1);

    // Lockout entry, blink pattern, ignored open attempt
    fail_pulse();
    fail_pulse();
    chk("pre_lock_cnt", 32'(fail_cnt), 32'd2);
    fail_n = 1'b0;
    tick(3);
    fail_n   = 1'b1;
    lock_cnt = 0;
    unsafe   = 0;
    for (int k = 0; k < 25; k++) begin
      if (lockout === 1'b1) lock_cnt++;
      if (safe_open_n !== 1'b1) unsafe++;
      chk($sformatf("lock_k%0d", k), 32'(lockout), (k < 20) ? 32'd1 : 32'd0);
      chk($sformatf("blink_k%0d", k), 32'(alarm_led_n),
          (k < 20) ? 32'((k / 2) % 2) : 32'd1);
      chk($sformatf("lcnt_k%0d", k), 32'(fail_cnt), (k < 20) ? 32'd3 : 32'd0);
`ifdef SAFE_LOCK_BUZZER_EN
      chk($sformatf("buzz_k%0d", k), 32'(buzzer),
          (k < 20) ? 32'(((k / 3) % 2) == 0) : 32'd0);
`endif
      if (k == 3) open_n = 1'b0;
      if (k == 8) open_n = 1'b1;
      tick(1);
    end
    chk("lock_len", 32'(lock_cnt), 32'd20);
    chk("lock_no_open", 32'(unsafe), 32'd0);

    // Reset at lockout clock 7
    fail_pulse();
    fail_pulse();
    fail_n = 1'b0;
    tick(3);
    fail_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("rl_lock_k%0d", k), 32'(lockout), 32'd1);
`ifdef SAFE_LOCK_BUZZER_EN
      if (k < 6) chk($sformatf("rl_buzz_k%0d", k), 32'(buzzer), (k < 3) ? 32'd1 : 32'd0);
`endif
      tick(1);
    end
    rst_n = 1'b0;
    #1;
    chk("rl_safe", 32'(safe_open_n), 32'd1);
    chk("rl_alarm", 32'(alarm_led_n), 32'd1);
    chk("rl_lockout", 32'(lockout), 32'd0);
    chk("rl_fail_cnt", 32'(fail_cnt), 32'd0);
`ifdef SAFE_LOCK_BUZZER_EN
    chk("rl_buzzer", 32'(buzzer), 32'd0);
`endif
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("rl_after_lock", 32'(lockout), 32'd0);
    chk("rl_after_fcnt", 32'(fail_cnt), 32'd0);
    chk("rl_after_safe", 32'(safe_open_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
